// File: rtl/sram_req_adapter.sv
// sram_req_adapter: drives a byte-enabled SRAM macro (1-cycle registered read)
// from a valid/ready request channel and returns in-order responses via a 2-entry FIFO.
module sram_req_adapter #(
  parameter int address_width = 22,
  parameter int data_width    = 2
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic                       REQ_WRITE,
  input  logic [address_width-1:0]   REQ_ADDR,
  input  logic [1:0]                 REQ_SIZE,
  input  logic [(8<<data_width)-1:0] REQ_WDATA,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic                       RSP_WRITE,
  output logic                       RSP_ERR,
  output logic [(8<<data_width)-1:0] RSP_RDATA,
  output logic [address_width-1:0]   MEM_READ_ADDR,
  output logic                       MEM_OE,
  input  logic [(8<<data_width)-1:0] MEM_DATA_OUT,
  output logic [address_width-1:0]   MEM_WRITE_ADDR,
  output logic [(8<<data_width)-1:0] MEM_DATA_IN,
  output logic [(1<<data_width)-1:0] MEM_BE,
  output logic                       MEM_WE
);

  localparam int NB = 1 << data_width;
  localparam int DW = 8 << data_width;
  localparam int OW = (data_width > 0) ? data_width : 1;

  logic [OW-1:0]            req_off;
  logic                     size_err;
  logic [2:0]               align_mask;
  logic                     req_err;
  logic [2:0]               occupancy;
  logic                     rsp_valid;
  logic                     pop;
  logic                     accept;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [address_width-1:0] word_addr;
  logic [NB-1:0]            be;
  logic [DW-1:0]            rd_shifted;
  logic [DW-1:0]            rsp_fmt;

  logic          ready_en_q, ready_en_d;
  logic          inflight_q, inflight_d;
  logic          tag_write_q, tag_write_d;
  logic          tag_err_q, tag_err_d;
  logic [OW-1:0] tag_off_q, tag_off_d;
  logic [1:0]    tag_size_q, tag_size_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic [1:0]    fifo_write_q, fifo_write_d;
  logic [1:0]    fifo_err_q, fifo_err_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  // Byte lane offset within the SRAM word; a byte-wide SRAM has no lanes.
  if (data_width > 0) begin : g_off
    assign req_off = REQ_ADDR[OW-1:0];
  end else begin : g_off_none
    assign req_off = '0;
  end

  always_comb begin
    size_err   = int'(REQ_SIZE) > data_width;
    align_mask = 3'((4'd1 << REQ_SIZE) - 4'd1);
    req_err    = size_err || (|(REQ_ADDR[2:0] & align_mask));

    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    rsp_valid = (count_q != 2'd0);
    pop       = rsp_valid && RSP_READY;
    REQ_READY = ready_en_q && ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));
    accept    = REQ_VALID && REQ_READY;
    mem_rd    = accept && !REQ_WRITE && !req_err;
    mem_wr    = accept && REQ_WRITE && !req_err;
    word_addr = REQ_ADDR >> data_width;

    be = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(req_off)) && (i < int'(req_off) + (1 << int'(REQ_SIZE)))) begin
        be[i] = 1'b1;
      end
    end

    MEM_OE         = mem_rd;
    MEM_WE         = mem_wr;
    MEM_READ_ADDR  = mem_rd ? word_addr : '0;
    MEM_WRITE_ADDR = mem_wr ? word_addr : '0;
    MEM_BE         = mem_wr ? be : '0;
    MEM_DATA_IN    = mem_wr ? (REQ_WDATA << {req_off, 3'b000}) : '0;
  end

  // Align SRAM read data to bit 0 and zero the bytes beyond the access size.
  always_comb begin
    rd_shifted = MEM_DATA_OUT >> {tag_off_q, 3'b000};
    rsp_fmt    = '0;
    if (!tag_write_q && !tag_err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (i < (1 << int'(tag_size_q))) begin
          rsp_fmt[8*i +: 8] = rd_shifted[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    ready_en_d   = 1'b1;
    inflight_d   = accept;
    tag_write_d  = tag_write_q;
    tag_err_d    = tag_err_q;
    tag_off_d    = tag_off_q;
    tag_size_d   = tag_size_q;
    fifo_data_d  = fifo_data_q;
    fifo_write_d = fifo_write_q;
    fifo_err_d   = fifo_err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (accept) begin
      tag_write_d = REQ_WRITE;
      tag_err_d   = req_err;
      tag_off_d   = req_off;
      tag_size_d  = REQ_SIZE;
    end

    // Occupancy gating guarantees the FIFO has room whenever a tag lands.
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q]  = rsp_fmt;
      fifo_write_d[wr_ptr_q] = tag_write_q;
      fifo_err_d[wr_ptr_q]   = tag_err_q;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(inflight_q) - 2'(pop);

    RSP_VALID = rsp_valid;
    RSP_WRITE = rsp_valid && fifo_write_q[rd_ptr_q];
    RSP_ERR   = rsp_valid && fifo_err_q[rd_ptr_q];
    RSP_RDATA = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ready_en_q     <= 1'b0;
      inflight_q     <= 1'b0;
      tag_write_q    <= 1'b0;
      tag_err_q      <= 1'b0;
      tag_off_q      <= '0;
      tag_size_q     <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_write_q   <= '0;
      fifo_err_q     <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      inflight_q   <= inflight_d;
      tag_write_q  <= tag_write_d;
      tag_err_q    <= tag_err_d;
      tag_off_q    <= tag_off_d;
      tag_size_q   <= tag_size_d;
      fifo_data_q  <= fifo_data_d;
      fifo_write_q <= fifo_write_d;
      fifo_err_q   <= fifo_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule
